// File: rtl/uart_fifo_if.sv
// Host-side streaming port of the buffered UART.
// TX push and RX pop handshakes plus FIFO status and error flags.
interface uart_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic [LW-1:0]        tx_level;
   logic                 tx_busy;
   logic                 rx_valid;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_ready;
   logic [LW-1:0]        rx_level;
   logic                 rx_frame_err;
   logic                 rx_parity_err;
   logic                 rx_overrun;
   logic                 err_clear;

   modport master (
      output tx_valid, tx_data, rx_ready, err_clear,
      input  tx_ready, tx_level, tx_busy,
      input  rx_valid, rx_data, rx_level,
      input  rx_frame_err, rx_parity_err, rx_overrun
   );

   modport slave (
      input  tx_valid, tx_data, rx_ready, err_clear,
      output tx_ready, tx_level, tx_busy,
      output rx_valid, rx_data, rx_level,
      output rx_frame_err, rx_parity_err, rx_overrun
   );
endinterface

// File: rtl/uart_fifo.sv
// Full-duplex UART with TX/RX FIFOs, configurable framing and
// per-entry receive error flags carried alongside each byte.
module uart_fifo #(
   parameter int CLK_FREQ   = 29_625_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   uart_fifo_if.slave bus,
   output logic       tx,
   input  logic       rx
);
   localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int DB  = DATA_BITS;
   localparam int EW  = DB + 2;

   localparam logic [CW-1:0] DIVM1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALFM1 = CW'(DIV / 2 - 1);
   localparam logic [AW:0]   FULL   = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   ONE    = (AW + 1)'(1);
   localparam logic [2:0]    LB     = 3'(DB - 1);
   localparam logic [2:0]    SB     = 3'(STOP_BITS - 1);
   localparam logic          PEN    = (PARITY != 0);
   localparam logic          ODD    = (PARITY == 1);

   if (DIV < 4 || DB < 5 || DB > 8 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
   begin : g_bad_cfg
      $error("uart_fifo: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP
   } st_t;

   logic [1:0]    r_rst_s;
   logic          w_rst_n;

   logic [DB-1:0] r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_tx_wp, r_tx_rp;
   logic [AW:0]   r_tx_lvl;
   logic          w_tx_full, w_tx_ne, w_tx_push, w_tx_pop;
   logic [DB-1:0] w_tx_head;
   logic          w_tx_hpar, w_tx_last;
   st_t           r_tx_st;
   logic [CW-1:0] r_tx_cnt;
   logic [2:0]    r_tx_bit;
   logic [DB-1:0] r_tx_sh;
   logic          r_tx_par, r_tx;

   logic [1:0]    r_rx_s;
   logic          r_rx_d, w_rxs;
   st_t           r_rx_st;
   logic [CW-1:0] r_rx_cnt;
   logic [2:0]    r_rx_bit;
   logic [DB-1:0] r_rx_sh;
   logic          r_rx_pb;
   logic          w_rx_push, w_rx_perr, w_rx_wr, w_rx_pop;
   logic          w_rx_full, w_rx_ne;
   logic [EW-1:0] w_rx_wdata;
   logic [EW-1:0] r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rx_wp, r_rx_rp, w_rx_rp1;
   logic [AW:0]   r_rx_lvl;
   logic [EW-1:0] r_rx_head;
   logic          r_ovr;

   // reset asserts immediately, releases two clocks after rst_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_s <= 2'b00;
      else        r_rst_s <= {r_rst_s[0], 1'b1};
   end
   assign w_rst_n = r_rst_s[1];

   assign w_tx_full = (r_tx_lvl == FULL);
   assign w_tx_ne   = (r_tx_lvl != '0);
   assign w_tx_push = bus.tx_valid & ~w_tx_full;
   assign w_tx_head = r_tx_mem[r_tx_rp];
   assign w_tx_hpar = (^w_tx_head) ^ ODD;
   assign w_tx_last = (r_tx_st == S_STOP) && (r_tx_cnt == '0) &&
                      (r_tx_bit == SB);
   assign w_tx_pop  = w_tx_ne && ((r_tx_st == S_IDLE) || w_tx_last);

   // TX FIFO storage
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.tx_data;
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_lvl <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_lvl <= r_tx_lvl + 1'b1;
            2'b01:   r_tx_lvl <= r_tx_lvl - 1'b1;
            default: r_tx_lvl <= r_tx_lvl;
         endcase
      end
   end

   // TX framer; a pop at end of stop chains frames with no gap
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_tx_st  <= S_IDLE;
         r_tx_cnt <= '0;
         r_tx_bit <= '0;
         r_tx_sh  <= '0;
         r_tx_par <= 1'b0;
         r_tx     <= 1'b1;
      end else if (w_tx_pop) begin
         r_tx_st  <= S_START;
         r_tx_cnt <= DIVM1;
         r_tx_bit <= '0;
         r_tx_sh  <= w_tx_head;
         r_tx_par <= w_tx_hpar;
         r_tx     <= 1'b0;
      end else if (r_tx_st != S_IDLE && r_tx_cnt != '0) begin
         r_tx_cnt <= r_tx_cnt - 1'b1;
      end else begin
         case (r_tx_st)
            S_START: begin
               r_tx     <= r_tx_sh[0];
               r_tx_sh  <= r_tx_sh >> 1;
               r_tx_bit <= '0;
               r_tx_cnt <= DIVM1;
               r_tx_st  <= S_DATA;
            end
            S_DATA: begin
               r_tx_cnt <= DIVM1;
               if (r_tx_bit == LB) begin
                  r_tx_bit <= '0;
                  if (PEN) begin
                     r_tx    <= r_tx_par;
                     r_tx_st <= S_PAR;
                  end else begin
                     r_tx    <= 1'b1;
                     r_tx_st <= S_STOP;
                  end
               end else begin
                  r_tx_bit <= r_tx_bit + 1'b1;
                  r_tx     <= r_tx_sh[0];
                  r_tx_sh  <= r_tx_sh >> 1;
               end
            end
            S_PAR: begin
               r_tx     <= 1'b1;
               r_tx_bit <= '0;
               r_tx_cnt <= DIVM1;
               r_tx_st  <= S_STOP;
            end
            S_STOP: begin
               r_tx_cnt <= DIVM1;
               if (r_tx_bit == SB) r_tx_st  <= S_IDLE;
               else                r_tx_bit <= r_tx_bit + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign tx = r_tx;

   assign w_rxs      = r_rx_s[1];
   assign w_rx_push  = (r_rx_st == S_STOP) && (r_rx_cnt == '0);
   assign w_rx_perr  = PEN & (r_rx_pb ^ (^r_rx_sh) ^ ODD);
   assign w_rx_wdata = {~w_rxs, w_rx_perr, r_rx_sh};
   assign w_rx_full  = (r_rx_lvl == FULL);
   assign w_rx_ne    = (r_rx_lvl != '0);
   assign w_rx_pop   = bus.rx_ready & w_rx_ne;
   assign w_rx_wr    = w_rx_push & (~w_rx_full | w_rx_pop);
   assign w_rx_rp1   = r_rx_rp + 1'b1;

   // RX deframer; arms only on a falling edge, so a break pushes once
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_rx_s   <= 2'b11;
         r_rx_d   <= 1'b1;
         r_rx_st  <= S_IDLE;
         r_rx_cnt <= '0;
         r_rx_bit <= '0;
         r_rx_sh  <= '0;
         r_rx_pb  <= 1'b0;
      end else begin
         r_rx_s <= {r_rx_s[0], rx};
         r_rx_d <= w_rxs;
         if (r_rx_st != S_IDLE && r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
         end else begin
            case (r_rx_st)
               S_IDLE: begin
                  if (r_rx_d & ~w_rxs) begin
                     r_rx_st  <= S_START;
                     r_rx_cnt <= HALFM1;
                  end
               end
               S_START: begin
                  if (w_rxs) begin
                     r_rx_st <= S_IDLE;
                  end else begin
                     r_rx_st  <= S_DATA;
                     r_rx_cnt <= DIVM1;
                     r_rx_bit <= '0;
                  end
               end
               S_DATA: begin
                  r_rx_sh  <= {w_rxs, r_rx_sh[DB-1:1]};
                  r_rx_cnt <= DIVM1;
                  if (r_rx_bit == LB) r_rx_st  <= PEN ? S_PAR : S_STOP;
                  else                r_rx_bit <= r_rx_bit + 1'b1;
               end
               S_PAR: begin
                  r_rx_pb  <= w_rxs;
                  r_rx_cnt <= DIVM1;
                  r_rx_st  <= S_STOP;
               end
               S_STOP:  r_rx_st <= S_IDLE;
               default: r_rx_st <= S_IDLE;
            endcase
         end
      end
   end

   // RX FIFO storage
   always_ff @(posedge clk) begin
      if (w_rx_wr) r_rx_mem[r_rx_wp] <= w_rx_wdata;
   end

   // RX FIFO pointers, registered head entry and sticky overrun
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_rx_wp   <= '0;
         r_rx_rp   <= '0;
         r_rx_lvl  <= '0;
         r_rx_head <= '0;
         r_ovr     <= 1'b0;
      end else begin
         if (w_rx_wr)  r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop) r_rx_rp <= w_rx_rp1;
         case ({w_rx_wr, w_rx_pop})
            2'b10:   r_rx_lvl <= r_rx_lvl + 1'b1;
            2'b01:   r_rx_lvl <= r_rx_lvl - 1'b1;
            default: r_rx_lvl <= r_rx_lvl;
         endcase
         if (w_rx_wr && !w_rx_ne) begin
            r_rx_head <= w_rx_wdata;
         end else if (w_rx_pop) begin
            if (r_rx_lvl != ONE) r_rx_head <= r_rx_mem[w_rx_rp1];
            else if (w_rx_wr)    r_rx_head <= w_rx_wdata;
         end
         if (w_rx_push && !w_rx_wr) r_ovr <= 1'b1;
         else if (bus.err_clear)    r_ovr <= 1'b0;
      end
   end

   assign bus.tx_ready      = ~w_tx_full;
   assign bus.tx_level      = r_tx_lvl;
   assign bus.tx_busy       = w_tx_ne | (r_tx_st != S_IDLE);
   assign bus.rx_valid      = w_rx_ne;
   assign bus.rx_data       = r_rx_head[DB-1:0];
   assign bus.rx_parity_err = r_rx_head[DB];
   assign bus.rx_frame_err  = r_rx_head[DB+1];
   assign bus.rx_level      = r_rx_lvl;
   assign bus.rx_overrun    = r_ovr;
endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: 8N1 loopback instance and a 7E1 instance,
// both at ten clocks per bit with four-entry FIFOs.
module tb_uart_fifo;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic loop_a = 1'b0;
   logic rxd_a = 1'b1;
   logic rxd_b = 1'b1;
   logic tx_a, tx_b, rx_a, rx_b;
   int   n_chk = 0;
   int   n_err = 0;
   logic [9:0] q [$];

   always #5 clk = ~clk;

   uart_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
   uart_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifb ();

   assign rx_a = loop_a ? tx_a : rxd_a;
   assign rx_b = rxd_b;

   uart_fifo #(
      .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa), .tx(tx_a), .rx(rx_a)
   );

   uart_fifo #(
      .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb), .tx(tx_b), .rx(rx_b)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic setrx(input int which, input logic v);
      if (which == 0) rxd_a = v;
      else            rxd_b = v;
   endtask

   task automatic send_frame(input int which, input logic [7:0] d,
                             input int nb, input logic pen,
                             input logic pb, input logic sb);
      setrx(which, 1'b0);
      repeat (10) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         setrx(which, d[i]);
         repeat (10) @(negedge clk);
      end
      if (pen) begin
         setrx(which, pb);
         repeat (10) @(negedge clk);
      end
      setrx(which, sb);
      repeat (10) @(negedge clk);
      setrx(which, 1'b1);
      repeat (10) @(negedge clk);
   endtask

   task automatic drain(input int which, input int n);
      int got;
      int cyc;
      logic v;
      logic [9:0] obs;
      got = 0;
      cyc = 0;
      if (which == 0) ifa.rx_ready = 1'b1;
      else            ifb.rx_ready = 1'b1;
      while (got < n && cyc < 1500) begin
         if (which == 0) begin
            v   = ifa.rx_valid;
            obs = {ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_data};
         end else begin
            v   = ifb.rx_valid;
            obs = {ifb.rx_frame_err, ifb.rx_parity_err, 1'b0,
                   ifb.rx_data};
         end
         if (v && q.size() > 0) begin
            chk("rx_entry", 32'(obs), 32'(q.pop_front()));
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      ifa.rx_ready = 1'b0;
      ifb.rx_ready = 1'b0;
      chk("drain_count", got, n);
   endtask

   task automatic tx_frame(input logic [7:0] d);
      logic [9:0] f;
      f = {1'b1, d, 1'b0};
      ifa.tx_data  = d;
      ifa.tx_valid = 1'b1;
      @(negedge clk);
      ifa.tx_valid = 1'b0;
      chk("txf_level", 32'(ifa.tx_level), 1);
      chk("txf_idle", 32'(tx_a), 1);
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < 10; c++) begin
            chk("txf_bit", {ifa.tx_busy, tx_a}, {1'b1, f[k]});
            @(negedge clk);
         end
      end
      chk("txf_done", {ifa.tx_busy, tx_a}, 2'b01);
   endtask

   task automatic tx_burst(input logic [39:0] b, input int nexp);
      for (int i = 0; i < 5; i++) begin
         ifa.tx_data  = b[8*i +: 8];
         ifa.tx_valid = 1'b1;
         if (i < nexp) q.push_back({2'b00, b[8*i +: 8]});
         @(negedge clk);
      end
      ifa.tx_valid = 1'b0;
      chk("burst_full", {ifa.tx_ready, ifa.tx_level}, {1'b0, 3'd4});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      ifa.tx_valid = 1'b0; ifa.tx_data = '0;
      ifa.rx_ready = 1'b0; ifa.err_clear = 1'b0;
      ifb.tx_valid = 1'b0; ifb.tx_data = '0;
      ifb.rx_ready = 1'b0; ifb.err_clear = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_tx_a", {tx_a, ifa.tx_ready, ifa.tx_busy}, 3'b110);
      chk("rst_lvl_a", {ifa.tx_level, ifa.rx_level}, 0);
      chk("rst_rx_a", {ifa.rx_valid, ifa.rx_data, ifa.rx_frame_err,
                       ifa.rx_parity_err, ifa.rx_overrun}, 0);
      chk("rst_b", {tx_b, ifb.tx_ready, ifb.tx_busy, ifb.rx_valid,
                    ifb.rx_data, ifb.rx_level}, 32'h6 << 11);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      tx_frame(8'hA5);

      loop_a = 1'b1;
      repeat (5) @(negedge clk);
      tx_burst({8'h81, 8'h3C, 8'h55, 8'hFF, 8'h00}, 5);
      drain(0, 5);
      repeat (20) @(negedge clk);

      q.push_back({2'b01, 8'h41});
      send_frame(1, 8'h41, 7, 1'b1, 1'b1, 1'b1);
      q.push_back({2'b00, 8'h41});
      send_frame(1, 8'h41, 7, 1'b1, 1'b0, 1'b1);
      chk("b_level", 32'(ifb.rx_level), 2);
      drain(1, 2);

      loop_a = 1'b0;
      repeat (5) @(negedge clk);
      q.push_back({2'b10, 8'h12});
      send_frame(0, 8'h12, 8, 1'b0, 1'b0, 1'b0);
      drain(0, 1);
      rxd_a = 1'b0;
      repeat (3) @(negedge clk);
      rxd_a = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch", {ifa.rx_valid, ifa.rx_level}, 0);

      loop_a = 1'b1;
      tx_burst({8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 4);
      cyc = 0;
      while (ifa.tx_busy && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk("ovr_tx_idle", 32'(ifa.tx_busy), 0);
      repeat (20) @(negedge clk);
      chk("ovr_state", {ifa.rx_overrun, ifa.rx_level}, {1'b1, 3'd4});
      drain(0, 4);
      chk("ovr_sticky", 32'(ifa.rx_overrun), 1);
      ifa.err_clear = 1'b1;
      @(negedge clk);
      ifa.err_clear = 1'b0;
      chk("ovr_clear", 32'(ifa.rx_overrun), 0);

      loop_a = 1'b0;
      repeat (5) @(negedge clk);
      ifa.tx_data  = 8'h3C;
      ifa.tx_valid = 1'b1;
      @(negedge clk);
      ifa.tx_data  = 8'h96;
      @(negedge clk);
      ifa.tx_valid = 1'b0;
      repeat (23) @(negedge clk);
      chk("pre_rst", {tx_a, ifa.tx_level}, 0 << 3 | 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst", {tx_a, ifa.tx_level, ifa.tx_busy}, 5'b10000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      tx_frame(8'h5A);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
